// File: rtl/spi_read_serializer.sv
// ---------------------------------------------------------------------------
// spi_read_serializer
//
// SPI peripheral-side front end. It receives an MSB-first command byte
// {write_flag, start_address[ADDR_W-1:0]}. A read command fetches bytes from
// a register file and shifts them out on poci, MSB first. A write command
// parks the block in WRITE with the read port idle. Pulling full_rstn low
// (chip-select high, or system reset) ends any transaction.
//
// Build option: define ADDR_AUTOINC_EN to step the read address after every
// byte. When it is undefined, every byte re-reads the start address.
//
// Ports
//   spi_clk    in   SPI clock; all state advances on the rising edge
//   full_rstn  in   async active-low reset (cs AND rstn)
//   pico       in   controller-to-peripheral data, sampled on rising edge
//   poci       out  peripheral-to-controller data, updated on falling edge
//   rd_en      out  combinational read strobe to the register file
//   rd_addr    out  combinational read address, valid while rd_en=1
//   rdata      in   register-file data, combinational from rd_addr
//   is_read    out  registered; set once a read command is decoded
//   tx_bytes   out  registered, saturating count of bytes loaded for transmit
// ---------------------------------------------------------------------------
module spi_read_serializer #(
    parameter int ADDR_W = 7
) (
    input  logic              spi_clk,
    input  logic              full_rstn,
    input  logic              pico,
    output logic              poci,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rdata,
    output logic              is_read,
    output logic [7:0]        tx_bytes
);

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        bit_cnt_r;
    logic [ADDR_W-1:0] cmd_sr_r;
    logic [7:0]        tx_sr_r;
    logic [ADDR_W-1:0] addr_r;
    logic              is_read_r;
    logic [7:0]        tx_bytes_r;
    logic              poci_r;

    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] start_addr_s;

    // Address held for the following byte: stepped or held by build option.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef ADDR_AUTOINC_EN
        next_addr = a + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
        next_addr = a;
`endif
    endfunction

    // The last command bit is still on pico, so it is spliced in directly.
    assign start_addr_s = {cmd_sr_r[ADDR_W-2:0], pico};

    // Read strobe and address: first fetch at the end of the command byte,
    // then one fetch at the last bit of every transmitted byte.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = addr_r;
        if (!full_rstn) begin
            rd_en_s   = 1'b0;
            rd_addr_s = addr_r;
        end else begin
            case (state_r)
                ST_CMD: begin
                    if ((bit_cnt_r == 3'd7) && !cmd_sr_r[ADDR_W-1]) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = start_addr_s;
                    end else begin
                        rd_en_s   = 1'b0;
                        rd_addr_s = addr_r;
                    end
                end
                ST_READ: begin
                    if (bit_cnt_r == 3'd7) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = addr_r;
                    end else begin
                        rd_en_s   = 1'b0;
                        rd_addr_s = addr_r;
                    end
                end
                default: begin
                    rd_en_s   = 1'b0;
                    rd_addr_s = addr_r;
                end
            endcase
        end
    end

    // Command decode, transmit shift register, address and byte counter.
    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            state_r    <= ST_CMD;
            bit_cnt_r  <= 3'd0;
            cmd_sr_r   <= {ADDR_W{1'b0}};
            tx_sr_r    <= 8'd0;
            addr_r     <= {ADDR_W{1'b0}};
            is_read_r  <= 1'b0;
            tx_bytes_r <= 8'd0;
        end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (rd_en_s) begin
                addr_r <= next_addr(rd_addr_s);
                if (tx_bytes_r != 8'd255) begin
                    tx_bytes_r <= tx_bytes_r + 8'd1;
                end
            end
            case (state_r)
                ST_CMD: begin
                    cmd_sr_r <= {cmd_sr_r[ADDR_W-2:0], pico};
                    if (bit_cnt_r == 3'd7) begin
                        if (cmd_sr_r[ADDR_W-1]) begin
                            state_r <= ST_WRITE;
                        end else begin
                            state_r   <= ST_READ;
                            is_read_r <= 1'b1;
                            tx_sr_r   <= rdata;
                        end
                    end
                end
                ST_READ: begin
                    if (bit_cnt_r == 3'd7) begin
                        tx_sr_r <= rdata;
                    end else begin
                        tx_sr_r <= {tx_sr_r[6:0], 1'b0};
                    end
                end
                ST_WRITE: begin
                    state_r <= ST_WRITE;
                end
                default: begin
                    state_r <= ST_CMD;
                end
            endcase
        end
    end

    // Launch on the falling edge so the controller samples a settled bit
    // on the next rising edge; quiet outside READ.
    always_ff @(negedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            poci_r <= 1'b0;
        end else begin
            poci_r <= (state_r == ST_READ) ? tx_sr_r[7] : 1'b0;
        end
    end

    assign poci     = poci_r;
    assign rd_en    = rd_en_s;
    assign rd_addr  = rd_addr_s;
    assign is_read  = is_read_r;
    assign tx_bytes = tx_bytes_r;

endmodule

// File: tb/tb_spi_read_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for spi_read_serializer. Outputs are sampled 1 time unit before
// each rising edge k (k = 1, 2, ... counted from the end of reset). The
// expected values come from a transaction-level view:
// - a read command starting at address A returns bytes reg[A + b*INC],
//   where INC is 1 with ADDR_AUTOINC_EN and 0 without it.
// - bit j of byte b is seen before edge 9 + 8*b + j.
// - the register file is strobed before every edge that is a multiple of 8.
// - tx_bytes counts the strobes already taken, saturating at 255.
// ---------------------------------------------------------------------------
module tb_spi_read_serializer;

`ifdef ADDR_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic       spi_clk = 1'b0;
    logic       full_rstn = 1'b0;
    logic       pico = 1'b0;
    logic       poci;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [7:0] rdata;
    logic       is_read;
    logic [7:0] tx_bytes;

    logic [7:0] regs [0:127];

    int tests = 0;
    int fails = 0;

    spi_read_serializer #(.ADDR_W(7)) dut (
        .spi_clk  (spi_clk),
        .full_rstn(full_rstn),
        .pico     (pico),
        .poci     (poci),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rdata    (rdata),
        .is_read  (is_read),
        .tx_bytes (tx_bytes)
    );

    always #5 spi_clk = ~spi_clk;

    assign rdata = regs[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] byte_addr(input logic [6:0] start, input int b);
        byte_addr = 7'((int'(start) + b * INC) % 128);
    endfunction

    task automatic randomize_regs();
        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    endtask

    // Hold reset for three cycles checking the quiet output state.
    task automatic do_reset();
        full_rstn = 1'b0;
        @(negedge spi_clk);
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("rst_poci", 32'(poci), 32'd0);
            chk("rst_rd_en", 32'(rd_en), 32'd0);
            chk("rst_is_read", 32'(is_read), 32'd0);
            chk("rst_tx_bytes", 32'(tx_bytes), 32'd0);
            @(negedge spi_clk);
        end
        full_rstn = 1'b1;
    endtask

    // Send a command and run nclk rising edges in total, checking each one.
    task automatic do_txn(input logic [7:0] cmd, input int nclk);
        logic       rd;
        logic [6:0] start;
        logic       exp_rden;
        logic       exp_poci;
        logic [7:0] d;
        int         b;
        int         j;
        int         loads;
        rd    = ~cmd[7];
        start = cmd[6:0];
        for (int k = 1; k <= nclk; k++) begin
            pico = (k <= 8) ? cmd[8-k] : 1'($urandom);
            #4;
            exp_rden = rd && (k % 8 == 0);
            chk("rd_en", 32'(rd_en), 32'(exp_rden));
            if (exp_rden) chk("rd_addr", 32'(rd_addr), 32'(byte_addr(start, k / 8 - 1)));
            if (rd && k >= 9) begin
                b = (k - 9) / 8;
                j = (k - 9) % 8;
                d = regs[byte_addr(start, b)];
                exp_poci = d[7-j];
            end else begin
                exp_poci = 1'b0;
            end
            chk("poci", 32'(poci), 32'(exp_poci));
            loads = rd ? (k - 1) / 8 : 0;
            if (loads > 255) loads = 255;
            chk("tx_bytes", 32'(tx_bytes), 32'(loads));
            chk("is_read", 32'(is_read), 32'(rd && k >= 9));
            @(negedge spi_clk);
        end
    endtask

    initial begin
        randomize_regs();
        do_reset();

        // Read burst from register 5
        regs[5] = 8'hA5;
        regs[6] = 8'h3C;
        do_txn(8'h05, 24);
        do_reset();

        // Write command: read port idle, poci quiet
        do_txn(8'h85, 24);
        do_reset();

        // Address wrap from 127
        regs[127] = 8'hFF;
        regs[0]   = 8'h01;
        do_txn(8'h7F, 24);
        do_reset();

        // Abort in mid-read, then a fresh read from register 2
        do_txn(8'h33, 12);
        do_reset();
        do_txn(8'h02, 24);
        do_reset();

        // Random commands and lengths
        for (int t = 0; t < 12; t++) begin
            randomize_regs();
            do_txn(8'($urandom), 8 + int'($urandom_range(0, 40)));
            do_reset();
        end

        // Long read past the tx_bytes saturation point
        randomize_regs();
        do_txn({1'b0, 7'($urandom)}, 8 + 260 * 8);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
